// File: rtl/can_reg_pkg.sv
// can_reg_pkg: FSM states, register map and default write-protection window
package can_reg_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_e;
  localparam int ADR_MODE   = 0;
  localparam int ADR_CMD    = 1;
  localparam int ADR_STATUS = 2;
  localparam int ADR_IRQ    = 3;
  localparam int ADR_ACR0   = 4;
  localparam int ADR_ACR1   = 5;
  localparam int ADR_ACR2   = 6;
  localparam int ADR_ACR3   = 7;
  localparam int ADR_AMR0   = 8;
  localparam int ADR_AMR1   = 9;
  localparam int ADR_AMR2   = 10;
  localparam int ADR_AMR3   = 11;
  localparam int DEF_PROT_LO = ADR_ACR0;
  localparam int DEF_PROT_HI = ADR_AMR3;
endpackage

// File: rtl/can_reg_access_if.sv
// can_reg_access_if: Wishbone-classic slave bus bundle for the register front end
interface can_reg_access_if;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic [7:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, input wb_dat_o, wb_ack_o);
  modport slave  (input wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/can_reg_addr_dec.sv
// can_reg_addr_dec: one-hot register select with range flag, shared by write and read paths
module can_reg_addr_dec #(
  parameter int NUM_REGS = 32
) (
  input  logic [7:0]          adr,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel,
  output logic                in_range
);
  assign in_range = 32'(adr) < NUM_REGS;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
    assign sel[i] = en && in_range && adr == 8'(i);
  end
endmodule

// File: rtl/can_reg_access.sv
// can_reg_access: Wishbone slave to one-hot register-bank strobes with reset-mode write protection
module can_reg_access
  import can_reg_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int PROT_LO  = DEF_PROT_LO,
  parameter int PROT_HI  = DEF_PROT_HI
) (
  input  logic                  clk,
  input  logic                  rst_n,
  can_reg_access_if.slave       wb,
  input  logic                  reset_mode,
  input  logic [8*NUM_REGS-1:0] reg_rdata,
  output logic [NUM_REGS-1:0]   reg_we,
  output logic [7:0]            reg_wdata,
  output logic [NUM_REGS-1:0]   reg_re,
  output logic                  prot_err
);
  state_e state_q, state_d;
  logic [7:0] adr_q, adr_d, dat_o_q, dat_o_d, reg_wdata_q, reg_wdata_d, dec_adr, rd;
  logic we_q, we_d, ack_q, ack_d, prot_err_q, prot_err_d, req, prot, dec_en, in_range;
  logic [NUM_REGS-1:0] reg_we_q, reg_we_d, reg_re_q, reg_re_d, sel;
  assign req     = wb.wb_cyc_i && wb.wb_stb_i;
  assign prot    = wb.wb_we_i && !reset_mode && 32'(wb.wb_adr_i) >= PROT_LO && 32'(wb.wb_adr_i) <= PROT_HI;
  assign dec_adr = state_q == IDLE ? wb.wb_adr_i : adr_q;
  assign dec_en  = state_q == IDLE ? req && wb.wb_we_i && !prot : state_q == ACCESS && !we_q;
  can_reg_addr_dec #(.NUM_REGS(NUM_REGS)) u_dec (
    .adr      (dec_adr),
    .en       (dec_en),
    .sel      (sel),
    .in_range (in_range)
  );
  always_comb begin
    rd = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) rd |= sel[k] ? reg_rdata[8*k +: 8] : 8'h00;
  end
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    we_d        = we_q;
    dat_o_d     = dat_o_q;
    reg_wdata_d = reg_wdata_q;
    ack_d       = 1'b0;
    reg_we_d    = '0;
    reg_re_d    = '0;
    prot_err_d  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        state_d     = ACCESS;
        adr_d       = wb.wb_adr_i;
        we_d        = wb.wb_we_i;
        reg_we_d    = sel;
        prot_err_d  = prot;
        reg_wdata_d = wb.wb_we_i && in_range && !prot ? wb.wb_dat_i : reg_wdata_q;
      end
      ACCESS: begin
        state_d  = wb.wb_cyc_i ? ACK : RELEASE;
        ack_d    = wb.wb_cyc_i;
        reg_re_d = sel;
        dat_o_d  = we_q ? dat_o_q : rd;
      end
      ACK:     state_d = RELEASE;
      default: state_d = req ? RELEASE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      adr_q       <= 8'h00;
      we_q        <= 1'b0;
      dat_o_q     <= 8'h00;
      reg_wdata_q <= 8'h00;
      ack_q       <= 1'b0;
      reg_we_q    <= '0;
      reg_re_q    <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      dat_o_q     <= dat_o_d;
      reg_wdata_q <= reg_wdata_d;
      ack_q       <= ack_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      prot_err_q  <= prot_err_d;
    end
  end
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_o_q;
  assign reg_we      = reg_we_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_re      = reg_re_q;
  assign prot_err    = prot_err_q;
endmodule

// File: tb/tb_can_reg_access.sv
// tb_can_reg_access: randomized accesses checked against a register-map model with a simulated bank
module tb_can_reg_access;
  import can_reg_pkg::*;
  localparam int N = 32;
  logic clk = 1'b0, rst_n = 1'b0, reset_mode = 1'b0, bank_clr = 1'b1;
  logic [8*N-1:0] reg_rdata;
  logic [N-1:0] reg_we, reg_re;
  logic [7:0] reg_wdata;
  logic prot_err;
  int n_cmp = 0, n_err = 0;
  logic [7:0] bank [N];
  logic [7:0] mdl [N];
  logic [7:0] exp_dat = 8'h00, exp_wdata = 8'h00;
  logic [N-1:0] one = 1;
  can_reg_access_if wb ();
  can_reg_access #(.NUM_REGS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wb),
    .reset_mode (reset_mode),
    .reg_rdata  (reg_rdata),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .reg_re     (reg_re),
    .prot_err   (prot_err)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    for (int k = 0; k < N; k++)
      if (bank_clr) bank[k] <= 8'h00;
      else if (reg_we[k]) bank[k] <= reg_wdata;
      else if (reg_re[k] && (k == ADR_STATUS || k == ADR_IRQ)) bank[k] <= 8'h00;
  always_comb
    for (int k = 0; k < N; k++) reg_rdata[8*k +: 8] = bank[k];

  task automatic do_access(input logic we, input logic [7:0] adr, input logic [7:0] dat, input logic rm, input int hold, input string tag);
    logic valid, prot, wr_ok;
    logic [N-1:0] exp_we, exp_re;
    valid  = 32'(adr) < N;
    prot   = we && !rm && adr >= 8'(ADR_ACR0) && adr <= 8'(ADR_AMR3);
    wr_ok  = we && valid && !prot;
    exp_we = wr_ok ? one << adr : '0;
    exp_re = !we && valid ? one << adr : '0;
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr; wb.wb_dat_i = dat; reset_mode = rm;
    @(negedge clk);
    wb.wb_adr_i = 8'($urandom); wb.wb_dat_i = 8'($urandom); reset_mode = 1'($urandom);
    if (wr_ok) begin mdl[adr] = dat; exp_wdata = dat; end
    if (!we) begin
      exp_dat = valid ? mdl[adr] : 8'h00;
      if (valid && (adr == 8'(ADR_STATUS) || adr == 8'(ADR_IRQ))) mdl[adr] = 8'h00;
    end
    n_cmp += 5;
    if (reg_we !== exp_we) begin n_err++; $display("FAIL %s reg_we: got %h want %h", tag, reg_we, exp_we); end
    if (reg_wdata !== exp_wdata) begin n_err++; $display("FAIL %s reg_wdata: got %h want %h", tag, reg_wdata, exp_wdata); end
    if (prot_err !== prot) begin n_err++; $display("FAIL %s prot_err: got %b want %b", tag, prot_err, prot); end
    if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL %s early ack: got %b want 0", tag, wb.wb_ack_o); end
    if (reg_re !== '0) begin n_err++; $display("FAIL %s early reg_re: got %h want 0", tag, reg_re); end
    @(negedge clk);
    n_cmp += 5;
    if (wb.wb_ack_o !== 1'b1) begin n_err++; $display("FAIL %s ack: got %b want 1", tag, wb.wb_ack_o); end
    if (wb.wb_dat_o !== exp_dat) begin n_err++; $display("FAIL %s dat_o: got %h want %h", tag, wb.wb_dat_o, exp_dat); end
    if (reg_re !== exp_re) begin n_err++; $display("FAIL %s reg_re: got %h want %h", tag, reg_re, exp_re); end
    if (reg_we !== '0) begin n_err++; $display("FAIL %s late reg_we: got %h want 0", tag, reg_we); end
    if (prot_err !== 1'b0) begin n_err++; $display("FAIL %s late prot_err: got %b want 0", tag, prot_err); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_cmp += 3;
      if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL %s held ack %0d: got %b want 0", tag, h, wb.wb_ack_o); end
      if (reg_we !== '0) begin n_err++; $display("FAIL %s held reg_we %0d: got %h want 0", tag, h, reg_we); end
      if (reg_re !== '0) begin n_err++; $display("FAIL %s held reg_re %0d: got %h want 0", tag, h, reg_re); end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL reset ack: got %b want 0", wb.wb_ack_o); end
    if (wb.wb_dat_o !== 8'h00) begin n_err++; $display("FAIL reset dat_o: got %h want 00", wb.wb_dat_o); end
    if (reg_we !== '0) begin n_err++; $display("FAIL reset reg_we: got %h want 0", reg_we); end
    if (reg_re !== '0) begin n_err++; $display("FAIL reset reg_re: got %h want 0", reg_re); end
    if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL reset reg_wdata: got %h want 00", reg_wdata); end
    if (prot_err !== 1'b0) begin n_err++; $display("FAIL reset prot_err: got %b want 0", prot_err); end
    rst_n = 1'b1; bank_clr = 1'b0;
  endtask

  task automatic test_write;
    do_access(1'b1, 8'd0, 8'hA5, 1'b1, 0, "wr_mode");
    do_access(1'b1, 8'd3, 8'h5C, 1'b1, 0, "wr_irq");
  endtask

  task automatic test_read;
    do_access(1'b0, 8'd3, 8'h00, 1'b0, 0, "rd_irq");
    do_access(1'b0, 8'd3, 8'h00, 1'b0, 0, "rd_irq_cleared");
    do_access(1'b0, 8'd0, 8'h00, 1'b0, 0, "rd_mode");
  endtask

  task automatic test_prot;
    do_access(1'b1, 8'd6, 8'h11, 1'b0, 0, "prot_blocked");
    do_access(1'b1, 8'd6, 8'h11, 1'b1, 0, "prot_reset_mode");
    do_access(1'b1, 8'd4, 8'h22, 1'b0, 0, "prot_lo");
    do_access(1'b1, 8'd11, 8'h33, 1'b0, 0, "prot_hi");
    do_access(1'b1, 8'd12, 8'h44, 1'b0, 0, "prot_above");
    do_access(1'b0, 8'd6, 8'h00, 1'b0, 0, "prot_readback");
  endtask

  task automatic test_out_of_range;
    do_access(1'b0, 8'h40, 8'h00, 1'b0, 0, "oor_read");
    do_access(1'b1, 8'h40, 8'h99, 1'b0, 0, "oor_write");
    do_access(1'b0, 8'd31, 8'h00, 1'b0, 0, "last_read");
  endtask

  task automatic test_hold;
    do_access(1'b1, 8'd20, 8'h6E, 1'b1, 6, "hold");
    do_access(1'b0, 8'd20, 8'h00, 1'b1, 0, "hold_readback");
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 8'd1; wb.wb_dat_i = 8'h77; reset_mode = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (reg_we !== one << 1) begin n_err++; $display("FAIL arst pre reg_we: got %h want %h", reg_we, one << 1); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (reg_we !== '0) begin n_err++; $display("FAIL arst reg_we: got %h want 0", reg_we); end
    if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL arst reg_wdata: got %h want 00", reg_wdata); end
    if (wb.wb_dat_o !== 8'h00) begin n_err++; $display("FAIL arst dat_o: got %h want 00", wb.wb_dat_o); end
    if (prot_err !== 1'b0) begin n_err++; $display("FAIL arst prot_err: got %b want 0", prot_err); end
    exp_dat = 8'h00; exp_wdata = 8'h00;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL arst ack: got %b want 0", wb.wb_ack_o); end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_access(1'b0, 8'd1, 8'h00, 1'b0, 0, "arst_readback");
  endtask

  task automatic test_abort;
    do_access(1'b1, 8'd2, 8'h3C, 1'b1, 0, "abort_setup");
    @(negedge clk);
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0; wb.wb_adr_i = 8'd2;
    @(negedge clk);
    wb.wb_cyc_i = 1'b0;
    exp_dat = mdl[2]; mdl[2] = 8'h00;
    @(negedge clk);
    n_cmp += 3;
    if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL abort ack: got %b want 0", wb.wb_ack_o); end
    if (reg_re !== one << 2) begin n_err++; $display("FAIL abort reg_re: got %h want %h", reg_re, one << 2); end
    if (wb.wb_dat_o !== exp_dat) begin n_err++; $display("FAIL abort dat_o: got %h want %h", wb.wb_dat_o, exp_dat); end
    @(negedge clk);
    n_cmp += 2;
    if (reg_re !== '0) begin n_err++; $display("FAIL abort reg_re end: got %h want 0", reg_re); end
    if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL abort late ack: got %b want 0", wb.wb_ack_o); end
    wb.wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    do_access(1'b0, 8'd2, 8'h00, 1'b0, 0, "abort_cleared");
  endtask

  task automatic test_random;
    logic [7:0] a;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 7) == 0 ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      do_access(1'($urandom), a, 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_bank_final;
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (bank[k] !== mdl[k]) begin n_err++; $display("FAIL bank[%0d]: got %h want %h", k, bank[k], mdl[k]); end
    end
  endtask

  initial begin
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = 8'h00; wb.wb_dat_i = 8'h00;
    for (int k = 0; k < N; k++) mdl[k] = 8'h00;
    test_reset;
    test_write;
    test_read;
    test_prot;
    test_out_of_range;
    test_hold;
    test_async_reset;
    test_abort;
    test_random;
    test_bank_final;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/can_reg_access.md
Name: can_reg_access

Overview:
- Register-bank access front end of the CAN controller.
- Converts Wishbone-classic slave cycles into one-hot, single-cycle write strobes and write data for the bank of synchronous-reset 8-bit registers directly downstream.
- Returns read data muxed from those registers.
- Also provides:
  - read strobes for clear-on-read registers;
  - reset-mode write protection for acceptance-filter registers;
  - a fixed-latency acknowledge.

Parameters:
NUM_REGS, 32, number of 8-bit registers addressed (addresses 0..NUM_REGS-1)
PROT_LO, 4, lowest address writable only in reset mode
PROT_HI, 11, highest address writable only in reset mode

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wb_cyc_i  input  1  bus cycle valid
wb_stb_i  input  1  strobe
wb_we_i  input  1  1=write, 0=read
wb_adr_i  input  8  byte address
wb_dat_i  input  8  write data
wb_dat_o  output  8  read data, valid while wb_ack_o=1
wb_ack_o  output  1  single-cycle acknowledge
reset_mode  input  1  mode-register reset bit from the bank
reg_rdata  input  8*NUM_REGS  flattened register outputs; register k occupies bits [8k+7:8k]
reg_we  output  NUM_REGS  one-hot write enables to the bank
reg_wdata  output  8  write data to the bank
reg_re  output  NUM_REGS  one-hot single-cycle read strobes (clear-on-read)
prot_err  output  1  single-cycle pulse when a protected write is dropped

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state=IDLE;
  - wb_ack_o=0, wb_dat_o=0x00;
  - reg_we=0, reg_re=0, reg_wdata=0x00, prot_err=0;
  - the latched address and direction to 0.
- All outputs are registered.
- FSM states: IDLE, ACCESS, ACK, RELEASE.
- IDLE:
  - On wb_cyc_i&wb_stb_i sampled at edge E0, latch address, direction and data; go to ACCESS.
  - At the same edge, for a valid write (address<NUM_REGS and not blocked):
    - reg_we[addr]=1;
    - reg_wdata=wb_dat_i.
- ACCESS (cycle after E0):
  - reg_we is high for exactly this cycle; the bank captures the data at edge E1.
  - For a read, wb_dat_o <= reg_rdata[addr] at E1, or 0x00 if addr>=NUM_REGS.
  - For a read, reg_re[addr]=1 during the cycle after E1.
  - Go to ACK.
- ACK:
  - wb_ack_o=1 for exactly one cycle (the cycle after E1). Ack latency is fixed at 2 cycles after the request is sampled.
  - The bank sees the written value in the same cycle the ack is high.
  - Go to RELEASE.
- RELEASE:
  - Wait until wb_stb_i=0 or wb_cyc_i=0, then go to IDLE.
  - A held strobe never generates a second access.
- Protection: a write to PROT_LO..PROT_HI while reset_mode=0 is handled as follows:
  - no reg_we is issued;
  - prot_err pulses in the ACCESS cycle;
  - the ack is still given.
- reset_mode is sampled at E0.
- Out-of-range address:
  - writes are silently dropped, with an ack and no prot_err;
  - reads return 0x00, with no reg_re.
- Abort: if wb_cyc_i=0 during ACCESS, go to RELEASE with no ack.
  - A write already strobed stays committed.
  - A read still pulses reg_re. This is a decided behaviour: the clear-on-read side effect is committed once the access is sampled.
- wb_dat_o holds its last value outside the ack cycle. It is not cleared.
- The address is decoded from the latched copy only. Changing wb_adr_i after E0 has no effect.

Decomposition:
- Package can_reg_pkg holds:
  - the state enum (2-bit typedef);
  - the register address localparams (MODE=0, CMD=1, STATUS=2, IRQ=3, ACR0..AMR3=4..11);
  - default PROT_LO/PROT_HI.
- One combinational sub-module, can_reg_addr_dec:
  - input: address, plus enable;
  - outputs: one-hot NUM_REGS vector and in_range flag;
  - instanced once and shared by the write and read paths.

Test Plan:
- Write 0xA5 to addr 0 with reset_mode=1 (sampled at E0) -> reg_we[0]=1 and reg_wdata=0xA5 only in cycle E0+1; wb_ack_o=1 only in cycle E0+2.
- Read addr 3 with reg_rdata[31:24]=0x5C -> wb_dat_o=0x5C while ack high at E0+2; reg_re[3] high exactly one cycle; no reg_we.
- Write 0x11 to addr 6 with reset_mode=0 -> reg_we all-zero; prot_err one pulse; ack at E0+2. Repeat with reset_mode=1 -> reg_we[6] pulse and no prot_err.
- Read addr 0x40 (>=NUM_REGS) -> wb_dat_o=0x00 with ack; reg_re all-zero. Write 0x40 -> ack with no reg_we and no prot_err.
- Hold stb/cyc high for 6 cycles after the ack -> exactly one ack and one reg_we; the next access is accepted only after stb drops.
- Assert rst_n=0 during ACCESS of a write -> outputs go to zero immediately (asynchronously) and no ack follows. Drop cyc during ACCESS of a read -> no ack, reg_re still pulses once.
